multicycle_phase_ctrl: RTL
==========================

// Module: multicycle_phase_ctrl
// PURPOSE
//   Multicycle-CPU phase controller driving the 2-bit IF/ID/EX/WB phase cycle
//   (00->01->10->11->00) consumed by the datapath.
//   Advances phases under a req/ack handshake with instruction/data memory,
//   emits per-phase write strobes and counts retired instructions.
//   Enters a terminal HALT on a decoded halt instruction or a memory timeout.
// PARAMETERS
//   TIMEOUT  15  max consecutive cycles mem_req=1 with mem_ack=0 before fault (>=1)
//   CNT_W    16  width of retired-instruction counter
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   reset        in   1      synchronous, active-high reset
//   run          in   1      permit fetch of a new instruction
//   mem_ack      in   1      memory completes current request this cycle
//   is_mem       in   1      decoded instr is load/store; sampled in ID
//   is_halt      in   1      decoded instr is halt; sampled in ID
//   phase        out  2      00 IF, 01 ID, 10 EX, 11 WB (00 while halted)
//   mem_req      out  1      memory request
//   ir_we        out  1      instruction-register write strobe
//   reg_we       out  1      register-file write strobe
//   pc_we        out  1      PC update strobe
//   retired      out  CNT_W  instructions completed, wraps mod 2^CNT_W
//   halted       out  1      in HALT state
//   timeout_err  out  1      sticky: HALT was entered by timeout
// BEHAVIOUR
//   Clock is clk; reset is synchronous and active-high.
//   Reset: state=IF, retired=0, timeout_err=0, wait count=0, is_mem_q=is_halt_q=0;
//     all strobes 0 next cycle (mem_req=0 while reset=1). Reset mid-instruction
//     abandons it, no strobe issued.
//   States IF, ID, EX, WB, HALT (3-bit internal). Strobes/mem_req are
//     combinational from state, registered flags and inputs; phase, retired,
//     halted, timeout_err are registered.
//   IF: mem_req=run. If run & mem_ack: ir_we=1, ->ID. run=0: hold, no counting.
//   ID: one cycle; is_mem_q<=is_mem, is_halt_q<=is_halt; is_halt ? ->HALT : ->EX.
//   EX: is_mem_q=0: one cycle ->WB. is_mem_q=1: mem_req=1, ->WB on mem_ack.
//   WB: reg_we=1, pc_we=1, retired<=retired+1 (wrap), ->IF. One cycle.
//   HALT: all strobes 0, mem_req=0, halted=1, phase=00; exits only by reset.
//   Halt instr: no reg_we/pc_we, retired unchanged.
//   Min latency: 4 cycles/instr (ack same cycle as req); each wait cycle adds 1.
//   Wait count: +1 each cycle mem_req=1 & mem_ack=0; cleared on state change.
//     Reaching TIMEOUT -> HALT, timeout_err<=1, no strobe that cycle.
//     mem_ack in the cycle count would reach TIMEOUT wins (normal advance).
//   mem_ack while mem_req=0: ignored. run dropping after IF: current instruction
//     completes; stall occurs at next IF.
//   retired at max & WB: wraps to 0, no flag.
// STRUCTURE
//   Shared package: phase encodings PH_IF/PH_ID/PH_EX/PH_WB (2'b00..2'b11) and
//     internal state encodings incl. ST_HALT; used by datapath and benches.
//   One sub-module: phase_wait_timer (count, clear, expire at TIMEOUT).
//   FSM + strobe decode + retire counter stay in this module.
// TESTING
//   1 reset 2 cycles, run=1, mem_ack=1 always, is_mem=0 -> phase 00,01,10,11
//     repeating; ir_we in IF, reg_we&pc_we in WB; retired=3 after 12 cycles.
//   2 is_mem=1 in ID, mem_ack low 3 cycles in EX -> EX lasts 4 cycles, mem_req
//     high throughout, instr takes 7 cycles, retired +1.
//   3 run=0 from reset 10 cycles -> phase stays 00, mem_req=0, timeout_err=0;
//     run=1 -> fetch on first ack.
//   4 TIMEOUT=15, mem_ack held 0 in IF -> after 15 req cycles halted=1,
//     timeout_err=1, mem_req=0; ack at cycle 15 instead -> ID, no error.
//   5 is_halt=1 in ID -> HALT next cycle, no reg_we/pc_we, retired unchanged;
//     reset mid-EX -> phase 00 next edge, retired=0, no WB strobes.
//   6 CNT_W=4, 16 instructions -> retired wraps 15->0.

Source files
------------

// File: rtl/multicycle_phase_ctrl_pkg.sv
// Shared encodings for the multicycle phase controller: datapath phase codes
// and the controller's internal state encoding.
package multicycle_phase_ctrl_pkg;

  localparam logic [1:0] PH_IF = 2'b00;
  localparam logic [1:0] PH_ID = 2'b01;
  localparam logic [1:0] PH_EX = 2'b10;
  localparam logic [1:0] PH_WB = 2'b11;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // HALT reports the IF code so the datapath sees an idle fetch phase.
  function automatic logic [1:0] phase_of(state_t s);
    case (s)
      ST_ID:   return PH_ID;
      ST_EX:   return PH_EX;
      ST_WB:   return PH_WB;
      default: return PH_IF;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_phase_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_phase_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             mem_ack;
  logic             is_mem;
  logic             is_halt;
  logic [1:0]       phase;
  logic             mem_req;
  logic             ir_we;
  logic             reg_we;
  logic             pc_we;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             timeout_err;

  modport master (
    input  run, mem_ack, is_mem, is_halt,
    output phase, mem_req, ir_we, reg_we, pc_we, retired, halted, timeout_err
  );

  modport slave (
    output run, mem_ack, is_mem, is_halt,
    input  phase, mem_req, ir_we, reg_we, pc_we, retired, halted, timeout_err
  );
endinterface

// File: rtl/multicycle_phase_ctrl_phase_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles within one phase and
// flags the cycle in which the count would reach TIMEOUT.
module phase_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam int            W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  assign expire = inc & (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_phase_ctrl.sv
// Multicycle-CPU phase controller: IF/ID/EX/WB sequencing under a memory
// req/ack handshake, write strobes, retired-instruction counter, terminal HALT.
module multicycle_phase_ctrl
  import multicycle_phase_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_phase_ctrl_if.master bus
);

  state_t           state, state_next;
  logic             is_mem_q, is_halt_q;
  logic             req, expire, leave;
  logic             ir_we, reg_we, pc_we;
  logic [1:0]       phase_q;
  logic             halted_q, timeout_err_q;
  logic [CNT_W-1:0] retired_q;

  // Request kept separate from the next-state logic so the timer sees no loop.
  always_comb begin
    req = 1'b0;
    if (!reset) begin
      case (state)
        ST_IF:   req = bus.run;
        ST_EX:   req = is_mem_q;
        default: req = 1'b0;
      endcase
    end
  end

  assign leave = (state_next != state);

  phase_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .inc    (req & ~bus.mem_ack),
    .clr    (leave),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    case (state)
      ST_IF: begin
        if (bus.run && bus.mem_ack) begin
          ir_we      = 1'b1;
          state_next = ST_ID;
        end else if (expire) begin
          state_next = ST_HALT;
        end
      end
      ST_ID:   state_next = bus.is_halt ? ST_HALT : ST_EX;
      ST_EX: begin
        if (!is_mem_q || bus.mem_ack) begin
          state_next = ST_WB;
        end else if (expire) begin
          state_next = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we     = ~is_halt_q;
        pc_we      = ~is_halt_q;
        state_next = ST_IF;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IF;
    endcase
    // Reset abandons the current instruction without issuing any strobe.
    if (reset) begin
      ir_we  = 1'b0;
      reg_we = 1'b0;
      pc_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IF;
      phase_q       <= PH_IF;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      retired_q     <= '0;
      is_mem_q      <= 1'b0;
      is_halt_q     <= 1'b0;
    end else begin
      state    <= state_next;
      phase_q  <= phase_of(state_next);
      halted_q <= (state_next == ST_HALT);
      if (expire) begin
        timeout_err_q <= 1'b1;
      end
      if (state == ST_ID) begin
        is_mem_q  <= bus.is_mem;
        is_halt_q <= bus.is_halt;
      end
      if (state == ST_WB && !is_halt_q) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.mem_req     = req;
  assign bus.ir_we       = ir_we;
  assign bus.reg_we      = reg_we;
  assign bus.pc_we       = pc_we;
  assign bus.phase       = phase_q;
  assign bus.halted      = halted_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.retired     = retired_q;

endmodule
